instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the single-cycle instruction decoder: accepts a decoded operation descriptor and emits the 32-bit machine word that the decoder maps back to the same control signals.
- Used by the instruction-memory loader and by self-check benches that round-trip encoder → decoder.
- Descriptor input uses a valid/ready handshake. A small FSM performs encoding and range checks. Encoded words are buffered in an output FIFO with their own valid/ready.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; must be a power of two, ≥2.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- in_class  in  3  0 DP, 1 MEM, 2 BR, 3 MUL, 4 UMULL, 5 SMULL, 6 FP, 7 illegal
- in_cond  in  4  condition field [31:28]; ignored for FP
- in_alu_op  in  2  0 ADD, 1 SUB, 2 AND, 3 ORR
- in_s  in  1  set-flags bit
- in_rd  in  4  destination (RdHi for long multiplies)
- in_rn  in  4  first source (RdLo for long multiplies)
- in_rm  in  4  second source register
- in_rs  in  4  multiply Rs register
- in_use_imm  in  1  DP second operand is immediate
- in_imm  in  32  DP immediate / MEM byte offset / BR byte offset (signed)
- in_load  in  1  MEM: 1 LDR, 0 STR
- in_fp_half  in  1  FP: 1 16-bit, 0 32-bit
- in_fp_mul  in  1  FP: 1 mul, 0 add
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head when out_valid & out_ready
- out_instr  out  32  FIFO head word
- err_pulse  out  1  one-cycle pulse when a descriptor is rejected
- err_count  out  ERR_CNT_W  saturating count of rejected descriptors
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset:
  - FSM to IDLE; FIFO empty.
  - out_valid=0, out_instr=0, in_ready=0 during the reset cycle, err_pulse=0, err_count=0, busy=0.
- FSM states: IDLE, ENCODE, (SEARCH, optional), PUSH.
  - IDLE: in_ready=1. On handshake, register the descriptor → ENCODE.
  - ENCODE: build the word and check ranges.
    - Error → err_pulse=1, err_count+1 (saturates at all-ones), return to IDLE. Nothing is pushed.
    - Otherwise → PUSH. With the optional feature, DP immediates that do not fit 8 bits go to SEARCH instead.
  - PUSH: write to the FIFO when not full, → IDLE. While the FIFO is full, stall in PUSH.
- Throughput: one word per 3 cycles, minimum. Latency from input handshake to out_valid is 3 cycles with the FIFO empty.
- Encodings (bit fields):
  - DP: [27:26]=00, [25]=in_use_imm, [24:21]=cmd, [20]=S, [19:16]=Rn, [15:12]=Rd.
    - cmd: ADD=0100, SUB=0010, AND=0000, ORR=1100.
    - Register form: [11:4]=0, [3:0]=Rm.
    - Immediate form: [11:8]=rot, [7:0]=imm8. Without the optional feature, rot=0 and in_imm>255 is an error.
  - MEM: [27:26]=01, [25]=0, [24]=1, [23]=1, [22:21]=00, [20]=in_load, [19:16]=Rn, [15:12]=Rd, [11:0]=in_imm[11:0].
    - Error if in_imm>4095.
    - S is ignored.
  - BR: [27:24]=1010, [23:0]=in_imm[25:2].
    - Error if in_imm[1:0]≠0.
    - Error if in_imm[31:25] is not the sign-extension of bit 25.
  - MUL/UMULL/SMULL: [27:26]=00, [25]=0, [20]=S, [11:8]=Rs, [7:4]=1001, [3:0]=Rm.
    - [24:21]: MUL=0000, UMULL=0100, SMULL=0110.
    - MUL: [19:16]=Rd, [15:12]=0.
    - Long forms: [19:16]=RdHi=in_rd, [15:12]=RdLo=in_rn.
    - Long forms with in_rd==in_rn are an error.
  - FP: [31:28]=1111 if in_fp_mul else 0000, [27:25]=000, [24:21]=1111 if in_fp_half else 0000, [20]=0, [19:16]=Rn, [15:12]=Rd, [11:7]=11111, [6:4]=000, [3:0]=Rm.
  - class 7: always an error.
- FIFO behaviour:
  - Simultaneous push and pop when full is legal; the pop frees a slot and the push completes in the same cycle.
  - Pop when empty has no effect.
  - out_instr holds its value while out_valid=0.
- Synchronous reset mid-operation discards the pending descriptor and all FIFO contents.

Optional Feature:
- Macro ENC_IMM_ROT_EN.
- Defined:
  - A DP immediate >255 enters SEARCH.
  - SEARCH tries rot=0..15, one per cycle: in_imm rotated left by 2·rot must be ≤255.
  - First match → PUSH with that rot.
  - No match after rot=15 → error, IDLE.
  - Worst case: 16 cycles in SEARCH.
- Undefined:
  - The SEARCH state is absent.
  - A DP immediate >255 is an error.

Test Plan:
- DP ADD, S=1, rd=2, rn=3, rm=4, cond=1110 → out_instr=0xE0932004, out_valid 3 cycles after the handshake.
- MEM LDR, rd=1, rn=13, imm=8 → 0xE59D1008. MEM with imm=4096 → err_pulse, err_count=1, no push.
- BR cond=0000, imm=-8 → 0x0AFFFFFE. BR with imm=6 → error.
- UMULL rd=5, rn=4, rs=3, rm=2, S=0 → 0xE0854392. SMULL with rd=rn=7 → error.
- FP: 16-bit mul, rd=1, rn=2, rm=3 → 0xF1E21F83. FP: 32-bit add, same registers → 0x00021F83.
- Hold out_ready=0 and send 5 DP descriptors with FIFO_DEPTH=4:
  - 4 are buffered; the FSM stalls in PUSH with busy=1.
  - Release out_ready → 5 words out in order.
  - With ENC_IMM_ROT_EN, DP imm=0xFF000000 → rot=4, imm8=0xFF.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Descriptor-in / machine-word-out handshake bundle for instr_encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [3:0]  in_cond;
  logic [1:0]  in_alu_op;
  logic        in_s;
  logic [3:0]  in_rd;
  logic [3:0]  in_rn;
  logic [3:0]  in_rm;
  logic [3:0]  in_rs;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic        in_load;
  logic        in_fp_half;
  logic        in_fp_mul;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;

  // Producer of descriptors and consumer of encoded words
  modport master (
    output in_valid, in_class, in_cond, in_alu_op, in_s, in_rd, in_rn, in_rm,
           in_rs, in_use_imm, in_imm, in_load, in_fp_half, in_fp_mul, out_ready,
    input  in_ready, out_valid, out_instr
  );

  // The encoder itself
  modport slave (
    input  in_valid, in_class, in_cond, in_alu_op, in_s, in_rd, in_rn, in_rm,
           in_rs, in_use_imm, in_imm, in_load, in_fp_half, in_fp_mul, out_ready,
    output in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder: turns a decoded operation descriptor into the 32-bit
// machine word, range-checks it, and buffers accepted words in a small FIFO.
// Optional macro ENC_IMM_ROT_EN adds a SEARCH state that finds a rotation
// for DP immediates wider than 8 bits.
module instr_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_encoder_if.slave       bus,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] C_DP = 3'd0, C_MEM = 3'd1, C_BR = 3'd2, C_MUL = 3'd3,
                         C_UMULL = 3'd4, C_SMULL = 3'd5, C_FP = 3'd6;

  typedef struct packed {
    logic [2:0]  cls;
    logic [3:0]  cond;
    logic [1:0]  alu_op;
    logic        s;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic        use_imm;
    logic [31:0] imm;
    logic        load;
    logic        fp_half;
    logic        fp_mul;
  } desc_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_PUSH   = 2'd2
`ifdef ENC_IMM_ROT_EN
    , S_SEARCH = 2'd3
`endif
  } state_t;

  state_t      state;
  desc_t       d_q;
  logic [31:0] word_q;
  logic [31:0] word_c;
  logic        err_c;
  logic        search_c;
  logic [3:0]  cmd_c;
  logic [3:0]  mul_op_c;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next_c;
  logic [CNT_W-1:0] count, cnt_after_pop_c, cnt_next_c;
  logic             pop_c, push_c, full_c;

`ifdef ENC_IMM_ROT_EN
  logic [3:0]  rot_q;
  logic [4:0]  shamt_c;
  logic [31:0] rot_val_c;
  logic        match_c;

  // Left-rotate the immediate by 2*rot; a fit means the value is below 256
  always_comb begin
    shamt_c   = {rot_q, 1'b0};
    rot_val_c = (d_q.imm << shamt_c) | (d_q.imm >> (6'd32 - {1'b0, shamt_c}));
    match_c   = (rot_val_c[31:8] == 24'd0);
  end
`endif

  // Word assembly and range checks for the registered descriptor
  always_comb begin
    word_c   = '0;
    err_c    = 1'b0;
    search_c = 1'b0;
    cmd_c    = 4'b0100;
    mul_op_c = 4'b0000;
    case (d_q.alu_op)
      2'd0:    cmd_c = 4'b0100;
      2'd1:    cmd_c = 4'b0010;
      2'd2:    cmd_c = 4'b0000;
      default: cmd_c = 4'b1100;
    endcase
    case (d_q.cls)
      C_UMULL: mul_op_c = 4'b0100;
      C_SMULL: mul_op_c = 4'b0110;
      default: mul_op_c = 4'b0000;
    endcase
    case (d_q.cls)
      C_DP: begin
        word_c = {d_q.cond, 2'b00, d_q.use_imm, cmd_c, d_q.s, d_q.rn, d_q.rd, 12'd0};
        if (!d_q.use_imm) begin
          word_c[3:0] = d_q.rm;
        end else if (d_q.imm <= 32'd255) begin
          word_c[7:0] = d_q.imm[7:0];
        end else begin
`ifdef ENC_IMM_ROT_EN
          search_c = 1'b1;
`else
          err_c = 1'b1;
`endif
        end
      end
      C_MEM: begin
        word_c = {d_q.cond, 2'b01, 1'b0, 1'b1, 1'b1, 2'b00, d_q.load, d_q.rn, d_q.rd,
                  d_q.imm[11:0]};
        err_c  = (d_q.imm > 32'd4095);
      end
      C_BR: begin
        word_c = {d_q.cond, 4'b1010, d_q.imm[25:2]};
        err_c  = (d_q.imm[1:0] != 2'b00) || (d_q.imm[31:25] != {7{d_q.imm[25]}});
      end
      C_MUL, C_UMULL, C_SMULL: begin
        word_c = {d_q.cond, 3'b000, mul_op_c, d_q.s, d_q.rd,
                  (d_q.cls == C_MUL) ? 4'd0 : d_q.rn, d_q.rs, 4'b1001, d_q.rm};
        err_c  = (d_q.cls != C_MUL) && (d_q.rd == d_q.rn);
      end
      C_FP: begin
        word_c = {d_q.fp_mul ? 4'hF : 4'h0, 3'b000, d_q.fp_half ? 4'hF : 4'h0, 1'b0,
                  d_q.rn, d_q.rd, 5'b11111, 3'b000, d_q.rm};
      end
      default: err_c = 1'b1;
    endcase
  end

  // FIFO handshake terms
  always_comb begin
    pop_c           = bus.out_valid & bus.out_ready;
    full_c          = (count == CNT_W'(FIFO_DEPTH));
    push_c          = (state == S_PUSH) && (!full_c || pop_c);
    cnt_after_pop_c = count - CNT_W'(pop_c);
    cnt_next_c      = cnt_after_pop_c + CNT_W'(push_c);
    rd_next_c       = rd_ptr + PTR_W'(pop_c);
  end

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      d_q          <= '0;
      word_q       <= '0;
      bus.in_ready <= 1'b0;
      busy         <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
`ifdef ENC_IMM_ROT_EN
      rot_q        <= '0;
`endif
    end else begin
      err_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            d_q <= '{cls: bus.in_class, cond: bus.in_cond, alu_op: bus.in_alu_op,
                     s: bus.in_s, rd: bus.in_rd, rn: bus.in_rn, rm: bus.in_rm,
                     rs: bus.in_rs, use_imm: bus.in_use_imm, imm: bus.in_imm,
                     load: bus.in_load, fp_half: bus.in_fp_half, fp_mul: bus.in_fp_mul};
            state        <= S_ENCODE;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        S_ENCODE: begin
          word_q <= word_c;
          if (err_c) begin
            state        <= S_IDLE;
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
            err_pulse    <= 1'b1;
            if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
          end else if (search_c) begin
`ifdef ENC_IMM_ROT_EN
            state <= S_SEARCH;
            rot_q <= '0;
`endif
          end else begin
            state <= S_PUSH;
          end
        end
`ifdef ENC_IMM_ROT_EN
        S_SEARCH: begin
          if (match_c) begin
            word_q[11:0] <= {rot_q, rot_val_c[7:0]};
            state        <= S_PUSH;
          end else if (rot_q == 4'd15) begin
            state        <= S_IDLE;
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
            err_pulse    <= 1'b1;
            if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
          end else begin
            rot_q <= rot_q + 4'd1;
          end
        end
`endif
        S_PUSH: begin
          if (push_c) begin
            state        <= S_IDLE;
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= word_q;
  end

  // FIFO pointers and registered head; head holds while the FIFO is empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr        <= rd_next_c;
      count         <= cnt_next_c;
      bus.out_valid <= (cnt_next_c != '0);
      if (cnt_after_pop_c != '0) begin
        bus.out_instr <= mem[rd_next_c];
      end else if (push_c) begin
        bus.out_instr <= word_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: behavioural encoding model, word scoreboard,
// directed literal cases plus randomized descriptors with random back-pressure.
module tb_instr_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       busy;

  always #5 clk = ~clk;

  instr_encoder_if bus ();

  instr_encoder #(.FIFO_DEPTH(4), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .busy      (busy)
  );

  typedef struct {
    int unsigned cls, cond, alu, s, rd, rn, rm, rs, use_imm, load, half, fmul;
    bit [31:0]   imm;
  } d_t;

  int          total = 0;
  int          bad = 0;
  int          exp_err = 0;
  int          seen_err = 0;
  int          mode = 2;      // 0 random out_ready, 1 held low, 2 held high
  bit [31:0]   exp_q[$];
  logic [31:0] prev_instr = 32'd0;

  task automatic check(input string name, input bit [63:0] act, input bit [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Encoding rules expressed as plain field arithmetic; bit 32 flags rejection
  function automatic bit [32:0] model(input d_t d);
    bit [31:0] w;
    bit        err;
    int        cmdtab[4];
    int        si;
    bit [63:0] t;
    bit [31:0] v;
    bit        found;
    cmdtab = '{4, 2, 0, 12};
    w = 32'd0;
    err = 1'b0;
    found = 1'b0;
    case (d.cls)
      0: begin
        w = (d.cond << 28) | (d.use_imm << 25) | (32'(cmdtab[d.alu]) << 21) |
            (d.s << 20) | (d.rn << 16) | (d.rd << 12);
        if (d.use_imm == 0) w = w | d.rm;
        else if (d.imm < 256) w = w | d.imm;
        else begin
`ifdef ENC_IMM_ROT_EN
          t = {d.imm, d.imm};
          for (int r = 0; r < 16; r++) begin
            v = t[63-2*r -: 32];
            if (!found && v < 256) begin
              found = 1'b1;
              w = w | (32'(r) << 8) | v;
            end
          end
          err = !found;
`else
          err = 1'b1;
`endif
        end
      end
      1: begin
        err = d.imm > 4095;
        w = (d.cond << 28) | (32'd1 << 26) | (32'd3 << 23) | (d.load << 20) |
            (d.rn << 16) | (d.rd << 12) | (d.imm % 4096);
      end
      2: begin
        si = $signed(d.imm);
        err = (d.imm % 4 != 0) || (si < -(1 << 25)) || (si >= (1 << 25));
        w = (d.cond << 28) | (32'd10 << 24) | ((d.imm >> 2) % (32'd1 << 24));
      end
      3, 4, 5: begin
        w = (d.cond << 28) | (d.s << 20) | (d.rd << 16) | (d.rs << 8) | (32'd9 << 4) | d.rm;
        if (d.cls == 4) w = w | (32'd4 << 21);
        if (d.cls == 5) w = w | (32'd6 << 21);
        if (d.cls != 3) begin
          w = w | (d.rn << 12);
          err = (d.rd == d.rn);
        end
      end
      6: begin
        w = (d.rn << 16) | (d.rd << 12) | (32'd31 << 7) | d.rm;
        if (d.fmul != 0) w = w | (32'd15 << 28);
        if (d.half != 0) w = w | (32'd15 << 21);
      end
      default: err = 1'b1;
    endcase
    return {err, w};
  endfunction

  function automatic d_t mk(input int unsigned cls, input int unsigned cond,
                            input int unsigned rd, input int unsigned rn,
                            input int unsigned rm, input bit [31:0] imm);
    d_t d;
    d = '{cls: cls, cond: cond, alu: 0, s: 0, rd: rd, rn: rn, rm: rm, rs: 0,
          use_imm: 0, load: 0, half: 0, fmul: 0, imm: imm};
    return d;
  endfunction

  function automatic d_t rand_desc();
    d_t d;
    int unsigned k;
    d.cls = $urandom_range(0, 7);
    d.cond = $urandom_range(0, 15);
    d.alu = $urandom_range(0, 3);
    d.s = $urandom_range(0, 1);
    d.rd = $urandom_range(0, 15);
    d.rn = ($urandom_range(0, 3) == 0) ? d.rd : $urandom_range(0, 15);
    d.rm = $urandom_range(0, 15);
    d.rs = $urandom_range(0, 15);
    d.use_imm = $urandom_range(0, 1);
    d.load = $urandom_range(0, 1);
    d.half = $urandom_range(0, 1);
    d.fmul = $urandom_range(0, 1);
    k = $urandom_range(0, 15);
    case ($urandom_range(0, 4))
      0: d.imm = $urandom_range(0, 255);
      1: d.imm = $urandom_range(0, 5000);
      2: d.imm = $urandom();
      3: d.imm = 32'($signed($urandom_range(0, 32'h0400_0000)) - 32'sh0200_0000);
      default: d.imm = 32'({$urandom_range(0, 255), $urandom_range(0, 255)} << (2 * k));
    endcase
    return d;
  endfunction

  // Random or held back-pressure on the output side
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       bus.out_ready = ($urandom_range(0, 3) != 0);
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Per-cycle compare: popped words against the scoreboard, head hold, error count
  always @(negedge clk) begin
    if (reset) begin
      prev_instr = bus.out_instr;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %08h expected no word", bus.out_instr);
        end else begin
          check("word", 64'(bus.out_instr), 64'(exp_q.pop_front()));
        end
      end
      if (!bus.out_valid) check("head_hold", 64'(bus.out_instr), 64'(prev_instr));
      prev_instr = bus.out_instr;
      if (err_pulse) begin
        seen_err++;
        if (seen_err > exp_err) begin
          total++;
          bad++;
          $display("FAIL unexpected_err: got pulse %0d expected %0d", seen_err, exp_err);
        end
        check("err_count", 64'(err_count), 64'((seen_err > 255) ? 255 : seen_err));
      end
    end
  end

  // Offer one descriptor, wait for acceptance, record its expectation; returns
  // one time unit after the accepting edge
  task automatic send(input d_t d);
    bit [32:0] r;
    bit ok;
    @(posedge clk);
    #1;
    bus.in_class = 3'(d.cls);
    bus.in_cond = 4'(d.cond);
    bus.in_alu_op = 2'(d.alu);
    bus.in_s = 1'(d.s);
    bus.in_rd = 4'(d.rd);
    bus.in_rn = 4'(d.rn);
    bus.in_rm = 4'(d.rm);
    bus.in_rs = 4'(d.rs);
    bus.in_use_imm = 1'(d.use_imm);
    bus.in_imm = d.imm;
    bus.in_load = 1'(d.load);
    bus.in_fp_half = 1'(d.half);
    bus.in_fp_mul = 1'(d.fmul);
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      r = model(d);
      if (r[32]) exp_err++;
      else exp_q.push_back(r[31:0]);
      #1;
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy && !bus.out_valid && exp_q.size() == 0 && seen_err == exp_err) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%0d out_valid=%0d words_left=%0d errs=%0d expected idle errs=%0d",
               busy, bus.out_valid, exp_q.size(), seen_err, exp_err);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1, "watchdog");
  end

  initial begin
    d_t d;
    bit [32:0] r;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_class = '0; bus.in_cond = '0; bus.in_alu_op = '0; bus.in_s = 1'b0;
    bus.in_rd = '0; bus.in_rn = '0; bus.in_rm = '0; bus.in_rs = '0;
    bus.in_use_imm = 1'b0; bus.in_imm = '0; bus.in_load = 1'b0;
    bus.in_fp_half = 1'b0; bus.in_fp_mul = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_instr", 64'(bus.out_instr), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_err_pulse", 64'(err_pulse), 64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    // DP ADD S=1 and its pipeline latency
    d = mk(0, 14, 2, 3, 4, 0);
    d.s = 1;
    check("pin_dp", 64'(model(d)), 64'(33'h0_E093_2004));
    send(d);
    check("lat_1", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    check("lat_2", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    check("lat_3", 64'(bus.out_valid), 64'(1));
    check("lat_word", 64'(bus.out_instr), 64'(32'hE093_2004));
    wait_idle();

    d = mk(1, 14, 1, 13, 0, 8);
    d.load = 1;
    check("pin_ldr", 64'(model(d)), 64'(33'h0_E59D_1008));
    send(d); wait_idle();
    d.imm = 4096;
    check("pin_mem_err", 64'(model(d) >> 32), 64'(1));
    send(d); wait_idle();
    check("mem_err_count", 64'(err_count), 64'(1));

    d = mk(2, 0, 0, 0, 0, 32'hFFFF_FFF8);
    check("pin_br", 64'(model(d)), 64'(33'h0_0AFF_FFFE));
    send(d); wait_idle();
    d.imm = 6;
    send(d); wait_idle();
    check("br_err_count", 64'(err_count), 64'(2));

    d = mk(4, 14, 5, 4, 2, 0);
    d.rs = 3;
    check("pin_umull", 64'(model(d)), 64'(33'h0_E085_4392));
    send(d); wait_idle();
    d = mk(5, 14, 7, 7, 2, 0);
    send(d); wait_idle();
    check("smull_err_count", 64'(err_count), 64'(3));

    d = mk(6, 5, 1, 2, 3, 0);
    d.half = 1; d.fmul = 1;
    check("pin_fp16_mul", 64'(model(d)), 64'(33'h0_F1E2_1F83));
    send(d); wait_idle();
    d.half = 0; d.fmul = 0;
    check("pin_fp32_add", 64'(model(d)), 64'(33'h0_0002_1F83));
    send(d); wait_idle();

    // Wide DP immediate: rotation found with the optional search, error without
    d = mk(0, 14, 2, 3, 0, 32'hFF00_0000);
    d.use_imm = 1;
`ifdef ENC_IMM_ROT_EN
    check("pin_rot", 64'(model(d)), 64'(33'h0_E283_24FF));
`else
    check("pin_wide_imm_err", 64'(model(d) >> 32), 64'(1));
`endif
    send(d); wait_idle();
    d.imm = 32'h0000_0101;
    send(d); wait_idle();

    // Five descriptors against a stalled consumer
    mode = 1;
    for (int i = 0; i < 5; i++) begin
      d = mk(0, 14, i, i + 1, i + 2, 0);
      d.alu = i % 4;
      send(d);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("full_busy", 64'(busy), 64'(1));
    check("full_in_ready", 64'(bus.in_ready), 64'(0));
    check("full_out_valid", 64'(bus.out_valid), 64'(1));
    r = model(mk(0, 14, 0, 1, 2, 0));
    check("full_head", 64'(bus.out_instr), 64'(r[31:0]));
    mode = 2;
    wait_idle();

    // Randomized traffic with random back-pressure
    mode = 0;
    for (int i = 0; i < 300; i++) begin
      send(rand_desc());
    end
    mode = 2;
    wait_idle();

    // Drive the error counter into saturation
    for (int i = 0; i < 260; i++) begin
      send(mk(7, 0, 0, 0, 0, 0));
    end
    wait_idle();
    check("err_sat", 64'(err_count), 64'(255));

    // Reset with words buffered and a descriptor in flight
    mode = 1;
    send(mk(0, 14, 1, 2, 3, 0));
    send(mk(0, 14, 4, 5, 6, 0));
    send(mk(3, 14, 7, 8, 9, 0));
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    exp_err = 0;
    seen_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_out_instr", 64'(bus.out_instr), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_err_count", 64'(err_count), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    mode = 2;
    d = mk(0, 14, 9, 10, 11, 0);
    send(d);
    wait_idle();

    check("final_err_total", 64'(seen_err), 64'(exp_err));
    check("final_words_left", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
